// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/writeback and drives
// all datapath enables and mux selects, with optional bne/ori decode and memory wait.
module mc_controller #(
   parameter bit EXT_EN   = 1'b0,
   parameter bit MEM_WAIT = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       memready,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic       pcen,
   output logic       zeroext,
   output logic [2:0] alucontrol,
   output logic [3:0] state
);

   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEMADR  = 4'd2;
   localparam logic [3:0] S_MEMRD   = 4'd3;
   localparam logic [3:0] S_MEMWB   = 4'd4;
   localparam logic [3:0] S_MEMWR   = 4'd5;
   localparam logic [3:0] S_RTYPEEX = 4'd6;
   localparam logic [3:0] S_RTYPEWB = 4'd7;
   localparam logic [3:0] S_BEQEX   = 4'd8;
   localparam logic [3:0] S_ADDIEX  = 4'd9;
   localparam logic [3:0] S_ADDIWB  = 4'd10;
   localparam logic [3:0] S_JEX     = 4'd11;
   localparam logic [3:0] S_ORIEX   = 4'd12;
   localparam logic [3:0] S_ORIWB   = 4'd13;
   localparam logic [3:0] S_BNEEX   = 4'd14;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   logic [3:0] state_q, state_d;
   logic [1:0] aluop;
   logic       pcwrite, branch, nbranch, mem_ok;

   // With single-cycle memory every access completes immediately.
   assign mem_ok = MEM_WAIT ? memready : 1'b1;
   assign state  = state_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:   if (mem_ok) state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTYPEEX;
               OP_BEQ:       state_d = S_BEQEX;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JEX;
               OP_ORI:       state_d = EXT_EN ? S_ORIEX : S_FETCH;
               OP_BNE:       state_d = EXT_EN ? S_BNEEX : S_FETCH;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   if (mem_ok) state_d = S_MEMWB;
         S_MEMWR:   if (mem_ok) state_d = S_FETCH;
         S_RTYPEEX: state_d = S_RTYPEWB;
         S_ADDIEX:  state_d = S_ADDIWB;
         S_ORIEX:   state_d = S_ORIWB;
         default:   state_d = S_FETCH;
      endcase
   end

   always_comb begin
      iord     = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      regwrite = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      pcsrc    = 2'b00;
      zeroext  = 1'b0;
      aluop    = 2'b00;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      nbranch  = 1'b0;
      case (state_q)
         S_FETCH: begin
            alusrcb = 2'b01;
            irwrite = mem_ok;
            pcwrite = mem_ok;
         end
         S_DECODE:  alusrcb = 2'b11;
         S_MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
         S_MEMRD:   iord = 1'b1;
         S_MEMWB:   begin memtoreg = 1'b1; regwrite = 1'b1; end
         S_MEMWR:   begin iord = 1'b1; memwrite = 1'b1; end
         S_RTYPEEX: begin alusrca = 1'b1; aluop = 2'b10; end
         S_RTYPEWB: begin regdst = 1'b1; regwrite = 1'b1; end
         S_BEQEX:   begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branch = 1'b1; end
         S_BNEEX:   begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; nbranch = 1'b1; end
         S_ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
         S_ADDIWB:  regwrite = 1'b1;
         S_JEX:     begin pcsrc = 2'b10; pcwrite = 1'b1; end
         S_ORIEX:   begin alusrca = 1'b1; alusrcb = 2'b10; zeroext = 1'b1; aluop = 2'b11; end
         S_ORIWB:   regwrite = 1'b1;
         default:   ;
      endcase
      // Architectural writes are suppressed for the whole reset pulse.
      pcen = ~reset & (pcwrite | (branch & zero) | (nbranch & ~zero));
      if (reset) begin
         irwrite  = 1'b0;
         regwrite = 1'b0;
         memwrite = 1'b0;
      end
   end

   always_comb begin
      case (aluop)
         2'b00: alucontrol = 3'b010;
         2'b01: alucontrol = 3'b110;
         2'b11: alucontrol = 3'b001;
         default: begin
            case (funct)
               6'b100000: alucontrol = 3'b010;
               6'b100010: alucontrol = 3'b110;
               6'b100100: alucontrol = 3'b000;
               6'b100101: alucontrol = 3'b001;
               6'b101010: alucontrol = 3'b111;
               default:   alucontrol = 3'b010;
            endcase
         end
      endcase
   end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: dut_a uses the base ISA with 1-cycle memory,
// dut_b enables bne/ori and the memory wait handshake.
module tb_mc_controller;

   logic       clk, reset, zero, memready;
   logic [5:0] op, funct;

   logic       a_iord, a_memwrite, a_irwrite, a_regdst, a_memtoreg, a_regwrite, a_alusrca;
   logic       a_pcen, a_zeroext;
   logic [1:0] a_alusrcb, a_pcsrc;
   logic [2:0] a_alucontrol;
   logic [3:0] a_state;

   logic       b_iord, b_memwrite, b_irwrite, b_regdst, b_memtoreg, b_regwrite, b_alusrca;
   logic       b_pcen, b_zeroext;
   logic [1:0] b_alusrcb, b_pcsrc;
   logic [2:0] b_alucontrol;
   logic [3:0] b_state;

   int errors = 0;
   int checks = 0;

   mc_controller #(.EXT_EN(1'b0), .MEM_WAIT(1'b0)) dut_a (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
      .iord(a_iord), .memwrite(a_memwrite), .irwrite(a_irwrite), .regdst(a_regdst),
      .memtoreg(a_memtoreg), .regwrite(a_regwrite), .alusrca(a_alusrca), .alusrcb(a_alusrcb),
      .pcsrc(a_pcsrc), .pcen(a_pcen), .zeroext(a_zeroext), .alucontrol(a_alucontrol),
      .state(a_state)
   );

   mc_controller #(.EXT_EN(1'b1), .MEM_WAIT(1'b1)) dut_b (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
      .iord(b_iord), .memwrite(b_memwrite), .irwrite(b_irwrite), .regdst(b_regdst),
      .memtoreg(b_memtoreg), .regwrite(b_regwrite), .alusrca(b_alusrca), .alusrcb(b_alusrcb),
      .pcsrc(b_pcsrc), .pcen(b_pcen), .zeroext(b_zeroext), .alucontrol(b_alucontrol),
      .state(b_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Pulses reset between clock edges; both DUTs then sit in FETCH.
   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      reset = 1'b0;
      #1;
   endtask

   initial begin
      reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0; memready = 1'b1;
      #2;
      chk("rst a.state", a_state, 8'd0);
      chk("rst a.pcen", a_pcen, 8'd0);
      chk("rst a.irwrite", a_irwrite, 8'd0);
      chk("rst a.alusrcb", a_alusrcb, 8'd1);
      chk("rst b.pcen", b_pcen, 8'd0);
      #5;
      reset = 1'b0;
      op = 6'b100011;
      #1;
      $display("lw: sequence 0,1,2,3,4,0");
      chk("lw fetch state", a_state, 8'd0);
      chk("lw fetch irwrite", a_irwrite, 8'd1);
      chk("lw fetch pcen", a_pcen, 8'd1);
      chk("lw fetch alucontrol", a_alucontrol, 8'd2);
      tick();
      chk("lw decode state", a_state, 8'd1);
      chk("lw decode alusrcb", a_alusrcb, 8'd3);
      chk("lw decode pcen", a_pcen, 8'd0);
      tick();
      chk("lw memadr state", a_state, 8'd2);
      chk("lw memadr alusrcb", a_alusrcb, 8'd2);
      chk("lw memadr alusrca", a_alusrca, 8'd1);
      tick();
      chk("lw memrd state", a_state, 8'd3);
      chk("lw memrd iord", a_iord, 8'd1);
      chk("lw memrd regwrite", a_regwrite, 8'd0);
      tick();
      chk("lw memwb state", a_state, 8'd4);
      chk("lw memwb regwrite", a_regwrite, 8'd1);
      chk("lw memwb memtoreg", a_memtoreg, 8'd1);
      tick();
      chk("lw done state", a_state, 8'd0);
      chk("lw done memtoreg", a_memtoreg, 8'd0);

      $display("rtype slt: sequence 0,1,6,7,0");
      op = 6'b000000; funct = 6'b101010;
      tick();
      chk("r decode state", a_state, 8'd1);
      tick();
      chk("r ex state", a_state, 8'd6);
      chk("r ex alucontrol", a_alucontrol, 8'd7);
      chk("r ex regwrite", a_regwrite, 8'd0);
      funct = 6'b100100;
      #1;
      chk("r ex and alucontrol", a_alucontrol, 8'd0);
      tick();
      chk("r wb state", a_state, 8'd7);
      chk("r wb regdst", a_regdst, 8'd1);
      chk("r wb regwrite", a_regwrite, 8'd1);
      tick();
      chk("r done state", a_state, 8'd0);

      $display("beq: taken then not taken");
      op = 6'b000100; zero = 1'b1;
      tick();
      tick();
      chk("beq ex state", a_state, 8'd8);
      chk("beq taken pcen", a_pcen, 8'd1);
      chk("beq pcsrc", a_pcsrc, 8'd1);
      chk("beq alucontrol", a_alucontrol, 8'd6);
      zero = 1'b0;
      #1;
      chk("beq not taken pcen", a_pcen, 8'd0);
      tick();
      chk("beq done state", a_state, 8'd0);

      $display("bne: base rejects, extended branches on zero=0");
      op = 6'b000101; zero = 1'b0;
      tick();
      tick();
      chk("bne a state", a_state, 8'd0);
      chk("bne b state", b_state, 8'd14);
      chk("bne taken pcen", b_pcen, 8'd1);
      chk("bne pcsrc", b_pcsrc, 8'd1);
      chk("bne alucontrol", b_alucontrol, 8'd6);
      zero = 1'b1;
      #1;
      chk("bne not taken pcen", b_pcen, 8'd0);
      pulse_reset();

      $display("ori: base rejects, extended executes");
      op = 6'b001101;
      tick();
      tick();
      chk("ori a state", a_state, 8'd0);
      chk("ori a memwrite", a_memwrite, 8'd0);
      chk("ori b state", b_state, 8'd12);
      chk("ori b zeroext", b_zeroext, 8'd1);
      chk("ori b alucontrol", b_alucontrol, 8'd1);
      tick();
      chk("ori a decode regwrite", a_regwrite, 8'd0);
      chk("ori b wb state", b_state, 8'd13);
      chk("ori b wb regwrite", b_regwrite, 8'd1);
      tick();
      chk("ori b done state", b_state, 8'd0);
      pulse_reset();

      $display("sw: reset while in MEMWR");
      op = 6'b101011;
      tick();
      tick();
      tick();
      chk("sw memwr state", a_state, 8'd5);
      chk("sw memwr memwrite", a_memwrite, 8'd1);
      reset = 1'b1;
      #1;
      chk("sw rst state", a_state, 8'd0);
      chk("sw rst memwrite", a_memwrite, 8'd0);
      chk("sw rst irwrite", a_irwrite, 8'd0);
      chk("sw rst alusrcb", a_alusrcb, 8'd1);
      tick();
      chk("sw rst held state", a_state, 8'd0);
      reset = 1'b0;
      tick();
      chk("sw post rst state", a_state, 8'd1);
      pulse_reset();

      $display("memwait: fetch stall then sw stall");
      memready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("wait fetch state", b_state, 8'd0);
         chk("wait fetch irwrite", b_irwrite, 8'd0);
         chk("wait fetch pcen", b_pcen, 8'd0);
         tick();
      end
      chk("wait fetch state", b_state, 8'd0);
      memready = 1'b1;
      #1;
      chk("ready fetch irwrite", b_irwrite, 8'd1);
      chk("ready fetch pcen", b_pcen, 8'd1);
      tick();
      chk("ready decode state", b_state, 8'd1);
      chk("ready decode irwrite", b_irwrite, 8'd0);
      tick();
      chk("wait memadr state", b_state, 8'd2);
      memready = 1'b0;
      tick();
      tick();
      chk("wait memwr state", b_state, 8'd5);
      chk("wait memwr memwrite", b_memwrite, 8'd1);
      chk("wait memwr iord", b_iord, 8'd1);
      memready = 1'b1;
      tick();
      chk("wait memwr done state", b_state, 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
